// File: rtl/sdm_mod_sequencer.sv
// sdm_mod_sequencer: paces PCM samples into a sigma-delta modulator with a tick divider, skid buffer and underrun hold.
module sdm_mod_sequencer #(
  parameter int DATA_W   = 16,
  parameter int OSR_LOG2 = 6,
  parameter int DIV_W    = 8,
  parameter int UCNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              mod_valid,
  output logic [DATA_W-1:0] mod_din,
  input  logic              mod_dout,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              underrun,
  output logic [UCNT_W-1:0] underrun_cnt,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_t;
  state_t state;
  logic [DIV_W-1:0] div_reg, div_cnt;
  logic [OSR_LOG2-1:0] tick_cnt;
  logic [DATA_W-1:0] cur, skid;
  logic skid_full, bit_q, ticking, tick, boundary, accept;
  always_comb begin
    ticking   = state == RUN || state == DRAIN;
    tick      = ticking && div_cnt == div_reg;
    boundary  = tick && &tick_cnt;
    s_ready   = state == PRIME || (state == RUN && (!skid_full || boundary));
    accept    = s_valid && s_ready;
    underrun  = state == RUN && boundary && !skid_full && !accept;
    mod_valid = tick;
    mod_din   = cur;
    busy      = state != IDLE;
    bit_out   = bit_valid ? mod_dout : bit_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      div_reg      <= '0;
      div_cnt      <= '0;
      tick_cnt     <= '0;
      cur          <= '0;
      skid         <= '0;
      skid_full    <= 1'b0;
      bit_valid    <= 1'b0;
      bit_q        <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      bit_valid <= tick;
      if (bit_valid) bit_q <= mod_dout;
      if (ticking) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) tick_cnt <= tick_cnt + 1'b1;
      end
      case (state)
        IDLE: if (enable) begin
          state        <= PRIME;
          div_reg      <= clk_div;
          underrun_cnt <= '0;
        end
        PRIME: if (accept) begin
          cur      <= s_data;
          div_cnt  <= '0;
          tick_cnt <= '0;
          state    <= RUN;
        end else if (!enable) state <= IDLE;
        RUN: begin
          // at a boundary the buffered sample wins; an empty buffer falls through to the live input, else hold
          if (boundary) cur <= skid_full ? skid : (accept ? s_data : cur);
          if (accept && (skid_full || !boundary)) begin
            skid      <= s_data;
            skid_full <= 1'b1;
          end else if (boundary) skid_full <= 1'b0;
          if (underrun && !(&underrun_cnt)) underrun_cnt <= underrun_cnt + 1'b1;
          if (!enable) state <= DRAIN;
        end
        DRAIN: if (boundary) begin
          state     <= IDLE;
          skid_full <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sdm_mod_sequencer.sv
// tb_sdm_mod_sequencer: randomized source and modulator stand-in, checked cycle by cycle against a sample-queue model.
module tb_sdm_mod_sequencer;
  localparam int DATA_W = 16, OSR_LOG2 = 2, DIV_W = 8, UCNT_W = 2;
  localparam int OSR = 1 << OSR_LOG2;
  localparam int UMAX = (1 << UCNT_W) - 1;
  logic clk = 0, rst, enable, s_valid, s_ready, mod_valid, mod_dout;
  logic bit_out, bit_valid, underrun, busy;
  logic [DIV_W-1:0] clk_div;
  logic [DATA_W-1:0] s_data, mod_din;
  logic [UCNT_W-1:0] underrun_cnt;
  int checks = 0, errors = 0, rate = 0;
  bit only_q = 0, strobe_seen = 0;
  logic [DATA_W-1:0] src_q[$];
  sdm_mod_sequencer #(.DATA_W(DATA_W), .OSR_LOG2(OSR_LOG2), .DIV_W(DIV_W), .UCNT_W(UCNT_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clk_div(clk_div), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .mod_valid(mod_valid), .mod_din(mod_din), .mod_dout(mod_dout), .bit_out(bit_out),
    .bit_valid(bit_valid), .underrun(underrun), .underrun_cnt(underrun_cnt), .busy(busy));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // sample source: holds each offer until accepted
  initial begin
    bit acc;
    s_valid = 0;
    s_data = 0;
    forever begin
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (acc || !s_valid) begin
        if (src_q.size() != 0) begin
          s_valid = 1;
          s_data = src_q.pop_front();
        end else if (!only_q && $urandom_range(0, 99) < rate) begin
          s_valid = 1;
          s_data = DATA_W'($urandom);
        end else s_valid = 0;
      end
    end
  end
  // modulator stand-in: new random output bit after every strobe edge
  initial begin
    mod_dout = 0;
    forever begin
      @(posedge clk);
      #1;
      if (strobe_seen) mod_dout = 1'($urandom);
    end
  end
  // reference model: accepted samples queue up; each plays for OSR ticks, an empty queue at a boundary holds
  initial begin
    int mst = 0, div_m = 0, cyc = 0, ticks = 0, ucnt_m = 0;
    logic [DATA_W-1:0] cur_m = 0;
    logic [DATA_W-1:0] pend[$];
    bit mv = 0, last_m = 0, prev_strobe = 0, strobe, bnd, rdy, urn, acc;
    forever begin
      @(negedge clk);
      #1;
      strobe = mst >= 2 && cyc == div_m;
      bnd = strobe && ticks == OSR - 1;
      rdy = mst == 1 || (mst == 2 && (pend.size() == 0 || bnd));
      acc = s_valid && rdy;
      urn = mst == 2 && bnd && pend.size() == 0 && !acc;
      if (mv) begin
        chk("busy", 32'(busy), 32'(mst != 0));
        chk("s_ready", 32'(s_ready), 32'(rdy));
        chk("mod_valid", 32'(mod_valid), 32'(strobe));
        chk("mod_din", 32'(mod_din), 32'(cur_m));
        chk("underrun", 32'(underrun), 32'(urn));
        chk("underrun_cnt", 32'(underrun_cnt), 32'(ucnt_m));
        chk("bit_valid", 32'(bit_valid), 32'(prev_strobe));
        chk("bit_out", 32'(bit_out), 32'(prev_strobe ? mod_dout : last_m));
      end
      strobe_seen = mod_valid;
      if (prev_strobe) last_m = mod_dout;
      prev_strobe = strobe;
      if (rst) begin
        mst = 0; cyc = 0; ticks = 0; ucnt_m = 0; cur_m = 0; div_m = 0;
        last_m = 0; prev_strobe = 0; pend.delete(); mv = 1;
      end else if (mst == 0) begin
        if (enable) begin
          mst = 1;
          div_m = int'(clk_div);
          ucnt_m = 0;
        end
      end else if (mst == 1) begin
        if (s_valid) begin
          cur_m = s_data; cyc = 0; ticks = 0; mst = 2;
        end else if (!enable) mst = 0;
      end else begin
        if (acc) pend.push_back(s_data);
        cyc = strobe ? 0 : cyc + 1;
        if (strobe) ticks = (ticks + 1) % OSR;
        if (mst == 2 && bnd) begin
          if (pend.size() != 0) cur_m = pend.pop_front();
          else if (ucnt_m < UMAX) ucnt_m++;
        end
        if (mst == 3 && bnd) begin
          mst = 0;
          pend.delete();
        end else if (mst == 2 && !enable) mst = 3;
      end
    end
  end
  initial begin
    rst = 1; enable = 0; clk_div = 0;
    wait_cyc(3);
    rst = 0;
    wait_cyc(2);
    clk_div = 1; src_q = '{16'h1000, 16'h2000}; rate = 100; enable = 1;
    wait_cyc(60);
    enable = 0; rate = 0;
    wait_cyc(20);
    only_q = 1; clk_div = 0; src_q.push_back(16'h1234); enable = 1;
    wait_cyc(14);
    src_q.push_back(16'h7FFF);
    wait_cyc(20);
    enable = 0;
    wait_cyc(12);
    src_q.push_back(16'h5555); enable = 1;
    wait_cyc(30);
    enable = 0;
    wait_cyc(12);
    only_q = 0; rate = 100; clk_div = 2; enable = 1;
    wait_cyc(25);
    rst = 1;
    wait_cyc(1);
    rst = 0;
    wait_cyc(30);
    enable = 0;
    wait_cyc(20);
    for (int e = 0; e < 8; e++) begin
      clk_div = DIV_W'($urandom_range(0, 3));
      rate = $urandom_range(30, 100);
      enable = 1;
      wait_cyc($urandom_range(10, 120));
      enable = 0;
      wait_cyc($urandom_range(0, 25));
    end
    enable = 0;
    wait_cyc(30);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
